useq_control: RTL and testbench

- Parametrised microprogram sequencer: the control-store address generator that drives the microcoded control section of the processor (datapath + control).
- Each cycle it selects the next control-store address from the MIR COND and JUMP ADDR fields, the PSR flags and the IR opcode.
- Over the fixed-width sequencer it adds a configurable address/opcode width, a microsubroutine return stack (CALL/RET), a stall input and a HALT/FAULT mode with sticky error flags.

---
 rtl/useq_pkg.sv | 28 ++
 rtl/useq_control_if.sv | 36 +++
 rtl/useq_return_stack.sv | 51 +++++
 rtl/useq_control.sv | 116 +++++++++++
 tb/tb_useq_control.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/useq_pkg.sv
// Shared encodings for the microprogram sequencer: COND field codes,
// PSR flag bit positions and the sequencer state enum.
package useq_pkg;

  localparam int unsigned COND_NEXT     = 0;
  localparam int unsigned COND_JMP_N    = 1;
  localparam int unsigned COND_JMP_Z    = 2;
  localparam int unsigned COND_JMP_V    = 3;
  localparam int unsigned COND_JMP_C    = 4;
  localparam int unsigned COND_JMP_IR13 = 5;
  localparam int unsigned COND_JMP      = 6;
  localparam int unsigned COND_DECODE   = 7;
  localparam int unsigned COND_CALL     = 8;
  localparam int unsigned COND_RET      = 9;
  localparam int unsigned COND_HALT     = 10;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } useq_state_e;

endpackage

// File: rtl/useq_control_if.sv
// MIR/IR/PSR inputs and CSAR/status outputs of the sequencer, bundled.
// Signal names keep the original top-level port names.
interface useq_control_if #(
  parameter int unsigned CS_ADDR_WIDTH = 11,
  parameter int unsigned OPCODE_WIDTH  = 8,
  parameter int unsigned COND_WIDTH    = 4,
  parameter int unsigned STACK_DEPTH   = 4
);
  localparam int unsigned DEPTH_WIDTH = $clog2(STACK_DEPTH) + 1;

  logic [COND_WIDTH-1:0]    useq_control_Cond_In;
  logic [CS_ADDR_WIDTH-1:0] useq_control_JumpAddr_In;
  logic [3:0]               useq_control_Flags_In;
  logic                     useq_control_IR13_In;
  logic [OPCODE_WIDTH-1:0]  useq_control_Opcode_In;
  logic                     useq_control_Stall_In;
  logic [CS_ADDR_WIDTH-1:0] useq_control_CSAddr_Out;
  logic                     useq_control_Halted_Out;
  logic                     useq_control_Overflow_Out;
  logic                     useq_control_Underflow_Out;
  logic [DEPTH_WIDTH-1:0]   useq_control_Depth_Out;

  modport master (
    output useq_control_Cond_In, useq_control_JumpAddr_In, useq_control_Flags_In,
           useq_control_IR13_In, useq_control_Opcode_In, useq_control_Stall_In,
    input  useq_control_CSAddr_Out, useq_control_Halted_Out, useq_control_Overflow_Out,
           useq_control_Underflow_Out, useq_control_Depth_Out
  );

  modport slave (
    input  useq_control_Cond_In, useq_control_JumpAddr_In, useq_control_Flags_In,
           useq_control_IR13_In, useq_control_Opcode_In, useq_control_Stall_In,
    output useq_control_CSAddr_Out, useq_control_Halted_Out, useq_control_Overflow_Out,
           useq_control_Underflow_Out, useq_control_Depth_Out
  );
endinterface

// File: rtl/useq_return_stack.sv
// Microsubroutine return-address LIFO. Only the occupancy pointer is reset;
// entry contents are don't-care until written.
module useq_return_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   depth
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      ptr_q, ptr_d;
  logic [AW-1:0]    wr_idx, rd_idx;

  always_comb begin
    wr_idx   = ptr_q[AW-1:0];
    rd_idx   = AW'(ptr_q - (AW+1)'(1));
    full     = (ptr_q == (AW+1)'(DEPTH));
    empty    = (ptr_q == '0);
    top_data = mem_q[rd_idx];
    depth    = ptr_q;
    mem_d    = mem_q;
    ptr_d    = ptr_q;
    // Push has priority; the caller never requests both in one cycle.
    if (push && !full) begin
      mem_d[wr_idx] = push_data;
      ptr_d         = ptr_q + (AW+1)'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/useq_control.sv
// Microprogram sequencer: registered CSAR selection from COND/JUMP ADDR,
// PSR flags and IR opcode, with return stack, stall and HALT/FAULT modes.
module useq_control
  import useq_pkg::*;
#(
  parameter int unsigned CS_ADDR_WIDTH = 11,
  parameter int unsigned OPCODE_WIDTH  = 8,
  parameter int unsigned COND_WIDTH    = 4,
  parameter int unsigned STACK_DEPTH   = 4,
  parameter int unsigned RESET_ADDR    = 0
) (
  input  logic           useq_control_CLOCK_50,
  input  logic           useq_control_Reset_InHigh,
  useq_control_if.slave  bus
);
  localparam int unsigned DW = $clog2(STACK_DEPTH) + 1;

  useq_state_e              state_q, state_d;
  logic [CS_ADDR_WIDTH-1:0] csar_q, csar_d;
  logic                     halted_q, halted_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;

  logic [CS_ADDR_WIDTH-1:0] csar_inc, decode_addr, jump_addr, stk_top;
  logic [31:0]              cond_ext;
  logic [3:0]               flags;
  logic                     push, pop, stk_full, stk_empty;
  logic [DW-1:0]            stk_depth;

  useq_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (CS_ADDR_WIDTH)
  ) u_stack (
    .clk       (useq_control_CLOCK_50),
    .rst       (useq_control_Reset_InHigh),
    .push      (push),
    .pop       (pop),
    .push_data (csar_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .depth     (stk_depth)
  );

  always_comb begin
    csar_inc    = csar_q + CS_ADDR_WIDTH'(1);
    decode_addr = CS_ADDR_WIDTH'({1'b1, bus.useq_control_Opcode_In, 2'b00});
    jump_addr   = bus.useq_control_JumpAddr_In;
    flags       = bus.useq_control_Flags_In;
    cond_ext    = 32'(bus.useq_control_Cond_In);

    state_d = state_q;
    csar_d  = csar_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;

    if (state_q == ST_RUN && !bus.useq_control_Stall_In) begin
      case (cond_ext)
        COND_JMP_N:    csar_d = flags[FLAG_N] ? jump_addr : csar_inc;
        COND_JMP_Z:    csar_d = flags[FLAG_Z] ? jump_addr : csar_inc;
        COND_JMP_V:    csar_d = flags[FLAG_V] ? jump_addr : csar_inc;
        COND_JMP_C:    csar_d = flags[FLAG_C] ? jump_addr : csar_inc;
        COND_JMP_IR13: csar_d = bus.useq_control_IR13_In ? jump_addr : csar_inc;
        COND_JMP:      csar_d = jump_addr;
        COND_DECODE:   csar_d = decode_addr;
        COND_CALL: begin
          if (stk_full) begin
            ovf_d   = 1'b1;
            state_d = ST_FAULT;
          end else begin
            push   = 1'b1;
            csar_d = jump_addr;
          end
        end
        COND_RET: begin
          if (stk_empty) begin
            unf_d   = 1'b1;
            state_d = ST_FAULT;
          end else begin
            pop    = 1'b1;
            csar_d = stk_top;
          end
        end
        COND_HALT:     state_d = ST_HALTED;
        default:       csar_d = csar_inc;
      endcase
    end

    halted_d = (state_d != ST_RUN);
  end

  always_ff @(posedge useq_control_CLOCK_50) begin
    if (useq_control_Reset_InHigh) begin
      state_q  <= ST_RUN;
      csar_q   <= CS_ADDR_WIDTH'(RESET_ADDR);
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      csar_q   <= csar_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.useq_control_CSAddr_Out    = csar_q;
  assign bus.useq_control_Halted_Out    = halted_q;
  assign bus.useq_control_Overflow_Out  = ovf_q;
  assign bus.useq_control_Underflow_Out = unf_q;
  assign bus.useq_control_Depth_Out     = stk_depth;

endmodule

// File: tb/tb_useq_control.sv
// Self-checking bench for useq_control: vector table plus hand-written
// corner sequences, with expected values queued at drive time.
module tb_useq_control;

  localparam logic [3:0] C_NEXT = 4'd0;
  localparam logic [3:0] C_JMP  = 4'd6;
  localparam logic [3:0] C_DEC  = 4'd7;
  localparam logic [3:0] C_CALL = 4'd8;
  localparam logic [3:0] C_RET  = 4'd9;
  localparam logic [3:0] C_HALT = 4'd10;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [3:0]  cond;
    logic [10:0] jump;
    logic [3:0]  flags;
    logic        ir13;
    logic [7:0]  opc;
    logic [10:0] e_addr;
    logic        e_halt;
    logic        e_ovf;
    logic        e_unf;
    logic [2:0]  e_depth;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned vec_no   = 0;
  vec_t tbl[$];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  useq_control_if #(
    .CS_ADDR_WIDTH (11),
    .OPCODE_WIDTH  (8),
    .COND_WIDTH    (4),
    .STACK_DEPTH   (4)
  ) bus ();

  useq_control #(
    .CS_ADDR_WIDTH (11),
    .OPCODE_WIDTH  (8),
    .COND_WIDTH    (4),
    .STACK_DEPTH   (4),
    .RESET_ADDR    (0)
  ) dut (
    .useq_control_CLOCK_50     (clk),
    .useq_control_Reset_InHigh (rst),
    .bus                       (bus)
  );

  function automatic vec_t mk(input logic r, input logic st, input logic [3:0] c,
                              input logic [10:0] j, input logic [3:0] f, input logic i13,
                              input logic [7:0] op, input logic [10:0] ea, input logic eh,
                              input logic eo, input logic eu, input logic [2:0] ed);
    vec_t v;
    v.rst = r; v.stall = st; v.cond = c; v.jump = j; v.flags = f; v.ir13 = i13;
    v.opc = op; v.e_addr = ea; v.e_halt = eh; v.e_ovf = eo; v.e_unf = eu; v.e_depth = ed;
    return v;
  endfunction

  function automatic vec_t rn(input logic [3:0] c, input logic [10:0] j, input logic [3:0] f,
                              input logic i13, input logic [7:0] op, input logic [10:0] ea,
                              input logic [2:0] ed);
    return mk(1'b0, 1'b0, c, j, f, i13, op, ea, 1'b0, 1'b0, 1'b0, ed);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", vec_no, nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst                          = v.rst;
    bus.useq_control_Stall_In    = v.stall;
    bus.useq_control_Cond_In     = v.cond;
    bus.useq_control_JumpAddr_In = v.jump;
    bus.useq_control_Flags_In    = v.flags;
    bus.useq_control_IR13_In     = v.ir13;
    bus.useq_control_Opcode_In   = v.opc;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL vec%0d scoreboard: got empty queue expected entry", vec_no);
    end else begin
      e = sb_q.pop_front();
      check("csaddr",    32'(bus.useq_control_CSAddr_Out),    32'(e.e_addr));
      check("halted",    32'(bus.useq_control_Halted_Out),    32'(e.e_halt));
      check("overflow",  32'(bus.useq_control_Overflow_Out),  32'(e.e_ovf));
      check("underflow", 32'(bus.useq_control_Underflow_Out), 32'(e.e_unf));
      check("depth",     32'(bus.useq_control_Depth_Out),     32'(e.e_depth));
    end
    vec_no++;
  endtask

  initial begin
    logic [3:0] own, other;
    logic       i13_own;

    bus.useq_control_Stall_In    = 1'b0;
    bus.useq_control_Cond_In     = '0;
    bus.useq_control_JumpAddr_In = '0;
    bus.useq_control_Flags_In    = '0;
    bus.useq_control_IR13_In     = 1'b0;
    bus.useq_control_Opcode_In   = '0;

    // Reset and sequential stepping
    tbl.push_back(mk(1'b1, 1'b0, C_NEXT, 11'h0, 4'h0, 1'b0, 8'h0, 11'h000, 1'b0, 1'b0, 1'b0, 3'd0));
    tbl.push_back(rn(C_NEXT, 11'h0, 4'h0, 1'b0, 8'h0, 11'h001, 3'd0));
    tbl.push_back(rn(C_NEXT, 11'h0, 4'h0, 1'b0, 8'h0, 11'h002, 3'd0));
    tbl.push_back(rn(C_NEXT, 11'h0, 4'h0, 1'b0, 8'h0, 11'h003, 3'd0));

    // Conditional jumps N,Z,V,C,IR13: others-set/own-clear falls through, own-set jumps
    for (int unsigned k = 0; k < 5; k++) begin
      own     = (k < 4) ? 4'(4'b1000 >> k) : 4'h0;
      other   = (k < 4) ? ~own : 4'hF;
      i13_own = (k == 4);
      tbl.push_back(rn(C_JMP, 11'h005, 4'h0, 1'b0, 8'h0, 11'h005, 3'd0));
      tbl.push_back(rn(4'(k + 1), 11'h040, other, 1'b0, 8'h0, 11'h006, 3'd0));
      tbl.push_back(rn(4'(k + 1), 11'h040, own, i13_own, 8'h0, 11'h040, 3'd0));
    end

    // Decode dispatch, increment wrap, unused codes
    tbl.push_back(rn(C_DEC,  11'h000, 4'h0, 1'b0, 8'h8A, 11'h628, 3'd0));
    tbl.push_back(rn(C_JMP,  11'h7FF, 4'h0, 1'b0, 8'h0,  11'h7FF, 3'd0));
    tbl.push_back(rn(C_NEXT, 11'h000, 4'h0, 1'b0, 8'h0,  11'h000, 3'd0));
    tbl.push_back(rn(4'd11,  11'h333, 4'hF, 1'b1, 8'h0,  11'h001, 3'd0));
    tbl.push_back(rn(4'd15,  11'h333, 4'hF, 1'b1, 8'h0,  11'h002, 3'd0));

    // Nested subroutine calls and returns
    tbl.push_back(rn(C_JMP,  11'h010, 4'h0, 1'b0, 8'h0, 11'h010, 3'd0));
    tbl.push_back(rn(C_CALL, 11'h020, 4'h0, 1'b0, 8'h0, 11'h020, 3'd1));
    tbl.push_back(rn(C_CALL, 11'h030, 4'h0, 1'b0, 8'h0, 11'h030, 3'd2));
    tbl.push_back(rn(C_RET,  11'h000, 4'h0, 1'b0, 8'h0, 11'h021, 3'd1));
    tbl.push_back(rn(C_RET,  11'h000, 4'h0, 1'b0, 8'h0, 11'h011, 3'd0));

    foreach (tbl[i]) apply(tbl[i]);

    // Overflow on fifth CALL, then inputs ignored in FAULT
    apply(mk(1'b1, 1'b0, C_NEXT, 11'h0, 4'h0, 1'b0, 8'h0, 11'h000, 1'b0, 1'b0, 1'b0, 3'd0));
    for (int unsigned k = 1; k <= 4; k++)
      apply(rn(C_CALL, 11'(k), 4'h0, 1'b0, 8'h0, 11'(k), 3'(k)));
    apply(mk(1'b0, 1'b0, C_CALL, 11'h005, 4'h0, 1'b0, 8'h0, 11'h004, 1'b1, 1'b1, 1'b0, 3'd4));
    apply(mk(1'b0, 1'b0, C_JMP,  11'h100, 4'h0, 1'b0, 8'h0, 11'h004, 1'b1, 1'b1, 1'b0, 3'd4));
    apply(mk(1'b0, 1'b0, C_RET,  11'h000, 4'h0, 1'b0, 8'h0, 11'h004, 1'b1, 1'b1, 1'b0, 3'd4));

    // Reset clears flags; RET from empty stack faults
    apply(mk(1'b1, 1'b0, C_JMP,  11'h100, 4'h0, 1'b0, 8'h0, 11'h000, 1'b0, 1'b0, 1'b0, 3'd0));
    apply(mk(1'b0, 1'b0, C_RET,  11'h000, 4'h0, 1'b0, 8'h0, 11'h000, 1'b1, 1'b0, 1'b1, 3'd0));
    apply(mk(1'b0, 1'b0, C_NEXT, 11'h000, 4'h0, 1'b0, 8'h0, 11'h000, 1'b1, 1'b0, 1'b1, 3'd0));

    // Stall holds CSAR and stack; reset wins over stall
    apply(mk(1'b1, 1'b0, C_NEXT, 11'h0, 4'h0, 1'b0, 8'h0, 11'h000, 1'b0, 1'b0, 1'b0, 3'd0));
    for (int unsigned k = 0; k < 3; k++)
      apply(mk(1'b0, 1'b1, C_JMP, 11'h055, 4'h0, 1'b0, 8'h0, 11'h000, 1'b0, 1'b0, 1'b0, 3'd0));
    apply(rn(C_JMP, 11'h055, 4'h0, 1'b0, 8'h0, 11'h055, 3'd0));
    apply(mk(1'b0, 1'b1, C_CALL, 11'h010, 4'h0, 1'b0, 8'h0, 11'h055, 1'b0, 1'b0, 1'b0, 3'd0));
    apply(mk(1'b1, 1'b1, C_JMP,  11'h123, 4'h0, 1'b0, 8'h0, 11'h000, 1'b0, 1'b0, 1'b0, 3'd0));

    // HALT freezes CSAR until reset
    apply(rn(C_NEXT, 11'h000, 4'h0, 1'b0, 8'h0, 11'h001, 3'd0));
    apply(mk(1'b0, 1'b0, C_HALT, 11'h000, 4'h0, 1'b0, 8'h0, 11'h001, 1'b1, 1'b0, 1'b0, 3'd0));
    apply(mk(1'b0, 1'b0, C_NEXT, 11'h000, 4'h0, 1'b0, 8'h0, 11'h001, 1'b1, 1'b0, 1'b0, 3'd0));
    apply(mk(1'b0, 1'b0, C_CALL, 11'h077, 4'h0, 1'b0, 8'h0, 11'h001, 1'b1, 1'b0, 1'b0, 3'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
